// File: rtl/alu32.sv
// rtl/alu32.sv - parallel 32-bit ALU: add, multiply, logic, subtract, shifts, bit reverse; all results registered
module alu32 (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] x,
   input  logic [31:0] y,
   input  logic        carry,
   output logic [31:0] summ,
   output logic        ocarry,
   output logic [31:0] mult_h,
   output logic [31:0] mult_l,
   output logic [31:0] zand,
   output logic [31:0] zor,
   output logic [31:0] zxor,
   output logic [31:0] znot,
   output logic [31:0] sub,
   output logic [31:0] ashiftl,
   output logic [31:0] ashiftr,
   output logic [31:0] lshiftl,
   output logic [31:0] lshiftr,
   output logic [31:0] revers
);

   logic [31:0] summ_d,    summ_q;
   logic        ocarry_d,  ocarry_q;
   logic [31:0] mult_h_d,  mult_h_q;
   logic [31:0] mult_l_d,  mult_l_q;
   logic [31:0] zand_d,    zand_q;
   logic [31:0] zor_d,     zor_q;
   logic [31:0] zxor_d,    zxor_q;
   logic [31:0] znot_d,    znot_q;
   logic [31:0] sub_d,     sub_q;
   logic [31:0] shl_d,     shl_q;
   logic [31:0] ashiftr_d, ashiftr_q;
   logic [31:0] lshiftr_d, lshiftr_q;
   logic [31:0] revers_d,  revers_q;

   logic [32:0] sum_full;
   logic [63:0] prod_full;
   logic [4:0]  shamt;

   assign shamt = y[4:0];

   always_comb begin
      sum_full  = {1'b0, x} + {1'b0, y} + {32'd0, carry};
      prod_full = {32'd0, x} * {32'd0, y};

      summ_d    = sum_full[31:0];
      ocarry_d  = sum_full[32];
      mult_h_d  = prod_full[63:32];
      mult_l_d  = prod_full[31:0];
      zand_d    = x & y;
      zor_d     = x | y;
      zxor_d    = x ^ y;
      znot_d    = ~x;
      sub_d     = x - y;

      // Arithmetic and logical left shifts are the same operation; one register feeds both ports.
      shl_d     = x << shamt;
      ashiftr_d = $unsigned($signed(x) >>> shamt);
      lshiftr_d = x >> shamt;

      revers_d  = '0;
      for (int i = 0; i < 32; i++) begin
         revers_d[i] = x[31-i];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         summ_q    <= '0;
         ocarry_q  <= 1'b0;
         mult_h_q  <= '0;
         mult_l_q  <= '0;
         zand_q    <= '0;
         zor_q     <= '0;
         zxor_q    <= '0;
         znot_q    <= '0;
         sub_q     <= '0;
         shl_q     <= '0;
         ashiftr_q <= '0;
         lshiftr_q <= '0;
         revers_q  <= '0;
      end else begin
         summ_q    <= summ_d;
         ocarry_q  <= ocarry_d;
         mult_h_q  <= mult_h_d;
         mult_l_q  <= mult_l_d;
         zand_q    <= zand_d;
         zor_q     <= zor_d;
         zxor_q    <= zxor_d;
         znot_q    <= znot_d;
         sub_q     <= sub_d;
         shl_q     <= shl_d;
         ashiftr_q <= ashiftr_d;
         lshiftr_q <= lshiftr_d;
         revers_q  <= revers_d;
      end
   end

   assign summ    = summ_q;
   assign ocarry  = ocarry_q;
   assign mult_h  = mult_h_q;
   assign mult_l  = mult_l_q;
   assign zand    = zand_q;
   assign zor     = zor_q;
   assign zxor    = zxor_q;
   assign znot    = znot_q;
   assign sub     = sub_q;
   assign ashiftl = shl_q;
   assign lshiftl = shl_q;
   assign ashiftr = ashiftr_q;
   assign lshiftr = lshiftr_q;
   assign revers  = revers_q;

endmodule

// File: tb/tb_alu32.sv
// tb/tb_alu32.sv - scoreboard bench for alu32 with a per-bit reference model
module tb_alu32;

   typedef logic [13:0][31:0] vec_t;

   logic        clk;
   logic        rst;
   logic [31:0] x, y;
   logic        carry;
   logic [31:0] summ, mult_h, mult_l, zand, zor, zxor, znot, sub;
   logic [31:0] ashiftl, ashiftr, lshiftl, lshiftr, revers;
   logic        ocarry;

   int   checks = 0;
   int   errors = 0;
   vec_t exp_q[$];
   string names[14] = '{"summ", "ocarry", "mult_h", "mult_l", "zand", "zor", "zxor",
                        "znot", "sub", "ashiftl", "ashiftr", "lshiftl", "lshiftr", "revers"};

   alu32 dut (
      .clk(clk), .rst(rst), .x(x), .y(y), .carry(carry),
      .summ(summ), .ocarry(ocarry), .mult_h(mult_h), .mult_l(mult_l),
      .zand(zand), .zor(zor), .zxor(zxor), .znot(znot), .sub(sub),
      .ashiftl(ashiftl), .ashiftr(ashiftr), .lshiftl(lshiftl), .lshiftr(lshiftr),
      .revers(revers)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t model(input logic [31:0] a, input logic [31:0] b, input logic c);
      vec_t        r;
      logic [63:0] s, p;
      int          amt;
      s   = 64'(a) + 64'(b) + 64'(c);
      p   = 64'(a) * 64'(b);
      amt = int'(b % 32);
      r[0] = s[31:0];
      r[1] = {31'd0, s[32]};
      r[2] = p[63:32];
      r[3] = p[31:0];
      r[4] = a & b;
      r[5] = a | b;
      r[6] = a ^ b;
      r[7] = ~a;
      r[8] = a - b;
      for (int i = 0; i < 32; i++) begin
         if (i >= amt) r[9][i] = a[i-amt];
         else          r[9][i] = 1'b0;
         if (i + amt < 32) begin
            r[10][i] = a[i+amt];
            r[12][i] = a[i+amt];
         end else begin
            r[10][i] = a[31];
            r[12][i] = 1'b0;
         end
         r[13][i] = a[31-i];
      end
      r[11] = r[9];
      return r;
   endfunction

   function automatic vec_t dut_vec();
      vec_t r;
      r[0] = summ;    r[1] = {31'd0, ocarry}; r[2] = mult_h;   r[3] = mult_l;
      r[4] = zand;    r[5] = zor;             r[6] = zxor;     r[7] = znot;
      r[8] = sub;     r[9] = ashiftl;         r[10] = ashiftr; r[11] = lshiftl;
      r[12] = lshiftr; r[13] = revers;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
      end
   endtask

   task automatic chk_zero(input string tag);
      vec_t a;
      a = dut_vec();
      for (int i = 0; i < 14; i++) chk({tag, "_", names[i]}, a[i], 32'd0);
   endtask

   task automatic drive_now(input logic [31:0] a, input logic [31:0] b, input logic c);
      x = a; y = b; carry = c;
      exp_q.push_back(model(a, b, c));
   endtask

   task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic c);
      @(negedge clk);
      drive_now(a, b, c);
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   always @(posedge clk) begin
      #1;
      if (rst) begin
         chk_zero("in_reset");
      end else if (exp_q.size() > 0) begin
         vec_t e, a;
         e = exp_q.pop_front();
         a = dut_vec();
         for (int i = 0; i < 14; i++) chk({"sb_", names[i]}, a[i], e[i]);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; x = '0; y = '0; carry = 1'b0;
      #1;
      chk_zero("por");
      repeat (2) @(posedge clk);
      #2;
      @(negedge clk);
      rst = 1'b0;
      drive_now(32'd2, 32'd6, 1'b0);
      settle();
      chk("v030_summ", summ, 32'd8);
      chk("v030_ocarry", {31'd0, ocarry}, 32'd0);
      chk("v030_mult_h", mult_h, 32'd0);
      chk("v030_mult_l", mult_l, 32'd12);
      apply(32'd2, 32'd6, 1'b1);
      settle();
      chk("v030c_summ", summ, 32'd9);
      chk("v030c_mult_l", mult_l, 32'd12);

      apply(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      settle();
      chk("v031_summ", summ, 32'hFFFF_FFFE);
      chk("v031_ocarry", {31'd0, ocarry}, 32'd1);
      apply(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
      settle();
      chk("v031_mult_h", mult_h, 32'h3FFF_FFFF);
      chk("v031_mult_l", mult_l, 32'h0000_0001);

      apply(32'h3333_3333, 32'hF0A5_C96B, 1'b0);
      settle();
      chk("v032_zand", zand, 32'h3021_0123);
      chk("v032_zor", zor, 32'hF3B7_FB7B);
      chk("v032_zxor", zxor, 32'hC396_FA58);
      chk("v032_znot", znot, 32'hCCCC_CCCC);

      apply(32'd10, 32'hFFFF_FFEC, 1'b0);
      settle();
      chk("v033_summ", summ, 32'hFFFF_FFF6);
      chk("v033_sub", sub, 32'd30);

      for (int k = 0; k < 2; k++) begin
         apply(32'h8000_0301, (k == 0) ? 32'd2 : 32'h22, 1'b0);
         settle();
         chk("v034_ashiftl", ashiftl, 32'h0000_0C04);
         chk("v034_lshiftl", lshiftl, 32'h0000_0C04);
         chk("v034_ashiftr", ashiftr, 32'hE000_00C0);
         chk("v034_lshiftr", lshiftr, 32'h2000_00C0);
      end

      apply(32'h1234_5678, 32'd0, 1'b1);
      apply(32'hFFFF_FFFF, 32'd31, 1'b0);
      apply(32'h8000_0000, 32'd31, 1'b1);
      for (int n = 0; n < 300; n++) begin
         logic [31:0] a, b;
         a = $urandom;
         b = $urandom;
         if (n % 5 == 0) b = $urandom_range(0, 63);
         if (n % 17 == 0) a = 32'hFFFF_FFFF;
         apply(a, b, 1'($urandom_range(0, 1)));
      end

      apply(32'hF0AA_137F, 32'd5, 1'b0);
      settle();
      chk("v035_revers", revers, 32'hFEC8_550F);
      #1;
      rst = 1'b1;
      #1;
      chk_zero("mid_reset");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      drive_now(32'hDEAD_BEEF, 32'h0000_0104, 1'b1);
      settle();
      chk("post_reset_summ", summ, 32'hDEAD_BFF4);
      chk("post_reset_lshiftl", lshiftl, 32'hEADB_EEF0);
      repeat (3) @(posedge clk);
      #2;
      chk("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
